// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU block.
// Operation encodings, Status flag bit positions and the signed-overflow
// helper used by the flag logic.
// Optional feature macro used across the block: ALU_OVF_STICKY_EN.
package alu_pkg;

  // Operation select encodings carried on ALUControl
  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  // Bit positions of the flags inside the 4-bit Status word {N,Z,C,V}
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned STATUS_W = 4;

  // Two's-complement overflow: both adder inputs carry the same sign and
  // the sum's sign differs from it. b_msb is the sign after any inversion.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    signed_ovf = (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  // True for operations that route the adder onto ALUResult
  function automatic logic is_arith(input alu_op_e op);
    is_arith = (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage : alu_pkg

// File: rtl/alu_if.sv
// alu_if: operand/result bundle between the datapath and the ALU.
// The master (datapath) drives operands and the operation select; the
// slave (alu) returns the combinational result, Zero and the registered
// flags. OvfSticky exists only when ALU_OVF_STICKY_EN is defined.
interface alu_if #(
  parameter int WIDTH = 32
) ();

  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [1:0]       ALUControl;
  logic             Zero;
  logic [WIDTH-1:0] ALUResult;
  logic [3:0]       Status;
`ifdef ALU_OVF_STICKY_EN
  logic             OvfSticky;
`endif

`ifdef ALU_OVF_STICKY_EN
  modport master (
    output SrcA, SrcB, ALUControl,
    input  Zero, ALUResult, Status, OvfSticky
  );

  modport slave (
    input  SrcA, SrcB, ALUControl,
    output Zero, ALUResult, Status, OvfSticky
  );
`else
  modport master (
    output SrcA, SrcB, ALUControl,
    input  Zero, ALUResult, Status
  );

  modport slave (
    input  SrcA, SrcB, ALUControl,
    output Zero, ALUResult, Status
  );
`endif

endinterface : alu_if

// File: rtl/alu_adder.sv
// alu_adder: WIDTH-bit ripple-style adder with carry-in and carry-out.
// ADD uses it directly; SUB feeds it the inverted B operand with cin = 1.
module alu_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] total_s;

  // Widen by one bit so the carry out of the MSB is kept
  always_comb begin
    total_s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  end

  assign sum  = total_s[WIDTH-1:0];
  assign cout = total_s[WIDTH];

endmodule : alu_adder

// File: rtl/alu.sv
// alu: 32-bit combinational ADD/SUB/AND/OR unit with a Zero output for
// branch decisions and a one-cycle-delayed {N,Z,C,V} status register.
// Optional: ALU_OVF_STICKY_EN adds a sticky signed-overflow flag that is
// set by any ADD/SUB overflow and cleared only by reset.
// ALUResult and Zero do not depend on reset; only the flag registers do.
// WIDTH must match the WIDTH of the connected alu_if instance.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  alu_if.slave bus
);

  alu_op_e              op_s;
  logic [WIDTH-1:0]     b_op_s;
  logic                 cin_s;
  logic [WIDTH-1:0]     sum_s;
  logic                 cout_s;
  logic [WIDTH-1:0]     result_s;
  logic                 zero_s;
  logic                 flag_n_s;
  logic                 flag_c_s;
  logic                 flag_v_s;
  logic [STATUS_W-1:0]  status_d;
  logic [STATUS_W-1:0]  status_q;
`ifdef ALU_OVF_STICKY_EN
  logic                 ovf_d;
  logic                 ovf_q;
`endif

  assign op_s = alu_op_e'(bus.ALUControl);

  // Adder operand conditioning: SUB is A + ~B + 1
  always_comb begin
    b_op_s = bus.SrcB;
    cin_s  = 1'b0;
    if (op_s == ALU_SUB) begin
      b_op_s = ~bus.SrcB;
      cin_s  = 1'b1;
    end else begin
      b_op_s = bus.SrcB;
      cin_s  = 1'b0;
    end
  end

  alu_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (bus.SrcA),
    .b    (b_op_s),
    .cin  (cin_s),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // Result mux selected by the operation code
  always_comb begin
    result_s = {WIDTH{1'b0}};
    case (op_s)
      ALU_ADD: result_s = sum_s;
      ALU_SUB: result_s = sum_s;
      ALU_AND: result_s = bus.SrcA & bus.SrcB;
      ALU_OR:  result_s = bus.SrcA | bus.SrcB;
      default: result_s = {WIDTH{1'b0}};
    endcase
  end

  // Flags of the current operation; C and V are only meaningful for ADD/SUB
  always_comb begin
    zero_s   = (result_s == {WIDTH{1'b0}});
    flag_n_s = result_s[WIDTH-1];
    flag_c_s = 1'b0;
    flag_v_s = 1'b0;
    if (is_arith(op_s)) begin
      flag_c_s = cout_s;
      flag_v_s = signed_ovf(bus.SrcA[WIDTH-1], b_op_s[WIDTH-1], sum_s[WIDTH-1]);
    end else begin
      flag_c_s = 1'b0;
      flag_v_s = 1'b0;
    end
  end

  // Next status word assembled at the fixed flag positions
  always_comb begin
    status_d         = {STATUS_W{1'b0}};
    status_d[FLAG_N] = flag_n_s;
    status_d[FLAG_Z] = zero_s;
    status_d[FLAG_C] = flag_c_s;
    status_d[FLAG_V] = flag_v_s;
  end

  // Status register: reloads every edge, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_q <= {STATUS_W{1'b0}};
    end else begin
      status_q <= status_d;
    end
  end

`ifdef ALU_OVF_STICKY_EN
  // Sticky overflow next value: once set it holds until reset
  always_comb begin
    ovf_d = ovf_q | flag_v_s;
  end

  // Sticky overflow register, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.OvfSticky = ovf_q;
`endif

  assign bus.ALUResult = result_s;
  assign bus.Zero      = zero_s;
  assign bus.Status    = status_q;

endmodule : alu

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for alu.
// Inputs change 1 time unit after a rising edge; combinational outputs are
// checked 1 unit after the change and Status 1 unit after the next edge.
module tb_alu;

  localparam int WIDTH = 32;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  alu_if #(.WIDTH(WIDTH)) bus ();

  alu #(.WIDTH(WIDTH)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [1:0] ctl);
    bus.SrcA       = a;
    bus.SrcB       = b;
    bus.ALUControl = ctl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ovf(input string tag, input logic exp);
`ifdef ALU_OVF_STICKY_EN
    check(tag, {31'd0, bus.OvfSticky}, {31'd0, exp});
`else
    if (exp === 1'bx) $display("unreachable %s", tag);
`endif
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.SrcA       = 32'd0;
    bus.SrcB       = 32'd0;
    bus.ALUControl = 2'b00;

    // Reset state
    tick();
    check("reset_status", {28'd0, bus.Status}, 32'h0000_0000);
    check_ovf("reset_ovf", 1'b0);
    #2 reset = 1'b0;

    // ADD 10 + 5
    apply(32'd10, 32'd5, 2'b00);
    check("add_result", bus.ALUResult, 32'd15);
    check("add_zero", {31'd0, bus.Zero}, 32'd0);
    tick();
    check("add_status", {28'd0, bus.Status}, 32'h0000_0000);

    // SUB 15 - 8, no borrow
    apply(32'd15, 32'd8, 2'b01);
    check("sub_result", bus.ALUResult, 32'd7);
    check("sub_zero", {31'd0, bus.Zero}, 32'd0);
    tick();
    check("sub_status", {28'd0, bus.Status}, 32'h0000_0002);

    // AND then OR of 2 and 3
    apply(32'd2, 32'd3, 2'b10);
    check("and_result", bus.ALUResult, 32'd2);
    check("and_zero", {31'd0, bus.Zero}, 32'd0);
    tick();
    check("and_status", {28'd0, bus.Status}, 32'h0000_0000);
    apply(32'd2, 32'd3, 2'b11);
    check("or_result", bus.ALUResult, 32'd3);
    tick();
    check("or_status", {28'd0, bus.Status}, 32'h0000_0000);

    // SUB 5 - 5 -> zero, no borrow
    apply(32'd5, 32'd5, 2'b01);
    check("sub_eq_result", bus.ALUResult, 32'd0);
    check("sub_eq_zero", {31'd0, bus.Zero}, 32'd1);
    tick();
    check("sub_eq_status", {28'd0, bus.Status}, 32'h0000_0006);

    // Signed overflow on ADD
    check_ovf("ovf_before", 1'b0);
    apply(32'h7FFF_FFFF, 32'd1, 2'b00);
    check("ovf_result", bus.ALUResult, 32'h8000_0000);
    tick();
    check("ovf_status", {28'd0, bus.Status}, 32'h0000_0009);
    check_ovf("ovf_set", 1'b1);

    // Non-overflowing ADD: sticky bit stays set
    apply(32'd1, 32'd1, 2'b00);
    check("add_small_result", bus.ALUResult, 32'd2);
    tick();
    check("add_small_status", {28'd0, bus.Status}, 32'h0000_0000);
    check_ovf("ovf_hold", 1'b1);

    // SUB with borrow: 3 - 5
    apply(32'd3, 32'd5, 2'b01);
    check("borrow_result", bus.ALUResult, 32'hFFFF_FFFE);
    tick();
    check("borrow_status", {28'd0, bus.Status}, 32'h0000_0008);

    // Unsigned wrap on ADD: carry out, result zero
    apply(32'hFFFF_FFFF, 32'd1, 2'b00);
    check("wrap_result", bus.ALUResult, 32'd0);
    check("wrap_zero", {31'd0, bus.Zero}, 32'd1);
    tick();
    check("wrap_status", {28'd0, bus.Status}, 32'h0000_0006);

    // Reset mid-cycle clears flags immediately; result stays combinational
    #2 reset = 1'b1;
    #1;
    check("rst_status", {28'd0, bus.Status}, 32'h0000_0000);
    check_ovf("rst_ovf", 1'b0);
    apply(32'h8000_0000, 32'd1, 2'b01);
    check("rst_result", bus.ALUResult, 32'h7FFF_FFFF);
    tick();
    check("rst_hold_status", {28'd0, bus.Status}, 32'h0000_0000);
    #2 reset = 1'b0;

    // First edge after reset: SUB overflow with no borrow
    tick();
    check("post_rst_status", {28'd0, bus.Status}, 32'h0000_0003);
    check_ovf("post_rst_ovf", 1'b1);

    // AND giving zero: C and V forced low
    apply(32'h0000_00F0, 32'h0000_000F, 2'b10);
    check("and_zero_result", bus.ALUResult, 32'd0);
    check("and_zero_flag", {31'd0, bus.Zero}, 32'd1);
    tick();
    check("and_zero_status", {28'd0, bus.Status}, 32'h0000_0004);

    // OR with sign bit set
    apply(32'h8000_0000, 32'h0000_0001, 2'b11);
    check("or_neg_result", bus.ALUResult, 32'h8000_0001);
    tick();
    check("or_neg_status", {28'd0, bus.Status}, 32'h0000_0008);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_alu
